tart_fake_antenna: RTL

//  Synthesisable antenna-data emulator; replaces the real radio front-end on rx_clk_16.

---
 rtl/tart_fake_pkg.sv | 22 ++
 rtl/tart_fake_lfsr.sv | 36 +++
 rtl/tart_fake_antenna.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tart_fake_pkg.sv
// Shared definitions for the TART fake-antenna emulator: pattern modes, FSM states,
// LFSR feedback taps and the default seed.
package tart_fake_pkg;

    typedef enum logic [1:0] {
        FAKE_RANDOM = 2'd0,
        FAKE_COUNT  = 2'd1,
        FAKE_WALK   = 2'd2,
        FAKE_CONST  = 2'd3
    } fake_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fake_state_t;

    // Taps for x^32+x^22+x^2+x+1 with a left-shifting register: bits 31, 21, 1, 0.
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2345;

endpackage

// File: rtl/tart_fake_lfsr.sv
// Seedable Fibonacci LFSR with step enable; a zero seed is replaced by SEED so the
// register can never lock up in the all-zero state.
module tart_fake_lfsr
    import tart_fake_pkg::*;
#(
    parameter int              W     = 32,
    parameter int              OUT_W = 24,
    parameter logic [W-1:0]    SEED  = W'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [W-1:0]     seed,
    input  logic             step,
    output logic [OUT_W-1:0] bits
);

    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);

    logic [W-1:0] lfsr_q;
    logic         fb;

    assign fb   = ^(lfsr_q & TAPS);
    assign bits = lfsr_q[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? SEED : seed;
        end else if (step) begin
            lfsr_q <= {lfsr_q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/tart_fake_antenna.sv
// Antenna-data emulator producing NANT one-bit samples per rx_clk_16 cycle in bursts.
// Optional per-channel delay lines are built when TART_FAKE_DELAY_EN is defined.
module tart_fake_antenna
    import tart_fake_pkg::*;
#(
    parameter int                NANT   = 24,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
    parameter int                LEN_W  = 24
`ifdef TART_FAKE_DELAY_EN
    ,
    parameter int                DW     = 3
`endif
) (
    input  logic              rx_clk_16,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [1:0]        mode_i,
    input  logic [LEN_W-1:0]  length_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [NANT-1:0]   pattern_i,
`ifdef TART_FAKE_DELAY_EN
    input  logic [NANT*DW-1:0] delay_i,
`endif
    output logic [NANT-1:0]   antenna_o,
    output logic              valid_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  count_o
);

    localparam logic [NANT-1:0] WALK_ONE = NANT'(1);

    fake_state_t       state_q, state_d;
    fake_mode_t        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  count_nxt;
    logic [LEN_W-1:0]  walk_pos;
    logic [NANT-1:0]   antenna_q;
    logic              valid_q;
    logic              done_q;
    logic              accept_start;
    logic              emit;
    logic [NANT-1:0]   lfsr_bits;
    logic [NANT-1:0]   pattern_d;
    logic [NANT-1:0]   sample;

    assign count_nxt = count_q + 1'b1;
    assign walk_pos  = count_q % LEN_W'(NANT);

    // Seeds may only change between bursts so a running sequence is never disturbed.
    tart_fake_lfsr #(
        .W     (LFSR_W),
        .OUT_W (NANT),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (rx_clk_16),
        .reset_n (reset_n),
        .load    (load_i && (state_q != ST_RUN)),
        .seed    (seed_i),
        .step    (emit),
        .bits    (lfsr_bits)
    );

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        emit         = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (start_i) begin
                    state_d      = ST_RUN;
                    accept_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else begin
                    emit = 1'b1;
                    if ((len_q != '0) && (count_nxt == len_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pattern_d = '0;
        unique case (mode_q)
            FAKE_RANDOM: pattern_d = lfsr_bits;
            FAKE_COUNT:  pattern_d = NANT'(count_q);
            FAKE_WALK:   pattern_d = WALK_ONE << walk_pos;
            FAKE_CONST:  pattern_d = pattern_i;
            default:     pattern_d = '0;
        endcase
    end

`ifdef TART_FAKE_DELAY_EN
    localparam int DEPTH = (1 << DW) - 1;

    logic [NANT-1:0][DEPTH-1:0] line_q;

    always_ff @(posedge rx_clk_16) begin
        if (!reset_n || accept_start) begin
            line_q <= '0;
        end else if (emit) begin
            for (int k = 0; k < NANT; k++) begin
                line_q[k] <= DEPTH'({line_q[k], pattern_d[k]});
            end
        end
    end

    // Tap 0 is the live pattern bit, tap d is the bit from d samples earlier.
    for (genvar k = 0; k < NANT; k++) begin : g_delay
        logic [DEPTH:0] taps;
        assign taps      = {line_q[k], pattern_d[k]};
        assign sample[k] = taps[delay_i[k*DW +: DW]];
    end
`else
    assign sample = pattern_d;
`endif

    always_ff @(posedge rx_clk_16) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= FAKE_RANDOM;
            len_q     <= '0;
            count_q   <= '0;
            antenna_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= emit;
            done_q  <= (state_q == ST_DONE) && (state_d == ST_DONE);
            if (accept_start) begin
                count_q <= '0;
                mode_q  <= fake_mode_t'(mode_i);
                len_q   <= length_i;
            end else if (emit) begin
                count_q   <= count_nxt;
                antenna_q <= sample;
            end
        end
    end

    assign antenna_o = antenna_q;
    assign valid_o   = valid_q;
    assign done_o    = done_q;
    assign count_o   = count_q;

endmodule
